// File: rtl/boot_pkg.sv
// Shared types for the I2C boot loader: FSM states, bit-engine
// commands and control-byte direction bits.
package boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RECOVER,
    START,
    TX_BYTE,
    TX_ACK,
    RSTART,
    RX_BYTE,
    RX_ACK,
    STOP,
    DONE,
    ERROR
  } state_t;

  typedef enum logic [2:0] {
    CMD_START,
    CMD_STOP,
    CMD_WBIT,
    CMD_RBIT,
    CMD_PULSE
  } cmd_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bit_ctrl.sv
// I2C bit engine: runs one START/STOP/data bit per command as four
// QUARTER-long phases and drives the open-drain enables.
module i2c_bit_ctrl
  import boot_pkg::*;
#(
  parameter int QUARTER = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  input  logic       wbit,
  output logic       busy,
  output logic       done,
  output logic       rbit,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [1:0]    nph;
  logic [2:0]    cmd_r;
  logic          wbit_r;
  logic          scl_q;
  logic          sda_q;
  logic          qlast;
  logic [1:0]    w_first;
  logic [1:0]    w_cur;
  logic [1:0]    w_next;

  // {scl_low, sda_low} for a command in a given phase
  function automatic logic [1:0] wave(
    input logic [2:0] c,
    input logic [1:0] ph,
    input logic       wb
  );
    logic       lo;
    logic [1:0] w;
    lo = (ph < 2'd2);
    case (c)
      CMD_START: w = {(ph == 2'd0) || (ph == 2'd3), ph[1]};
      CMD_STOP:  w = {lo, ph != 2'd3};
      CMD_WBIT:  w = {lo, ~wb};
      default:   w = {lo, 1'b0};
    endcase
    return w;
  endfunction

  assign qlast   = (qcnt == QW'(QUARTER - 1));
  assign nph     = phase + 2'd1;
  assign w_first = wave(cmd, 2'd0, wbit);
  assign w_cur   = wave(cmd_r, phase, wbit_r);
  assign w_next  = wave(cmd_r, nph, wbit_r);

  // Released combinationally so the bus frees on the reset cycle
  assign scl_oe = scl_q & ~rst;
  assign sda_oe = sda_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      rbit   <= 1'b1;
      qcnt   <= '0;
      phase  <= 2'd0;
      cmd_r  <= CMD_PULSE;
      wbit_r <= 1'b1;
      scl_q  <= 1'b0;
      sda_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (cmd_valid) begin
          busy   <= 1'b1;
          cmd_r  <= cmd;
          wbit_r <= wbit;
          qcnt   <= '0;
          phase  <= 2'd0;
          // SCL falls first; SDA follows a clk later inside Q0
          scl_q  <= w_first[1];
        end
      end else begin
        if (phase == 2'd2 && qlast) rbit <= sda_i;
        if (qlast) begin
          qcnt <= '0;
          if (phase == 2'd3) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            phase          <= nph;
            {scl_q, sda_q} <= w_next;
          end
        end else begin
          qcnt           <= qcnt + 1'b1;
          {scl_q, sda_q} <= w_cur;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_boot_loader.sv
// Boot loader: reads the EEPROM image over I2C after power-up and
// writes it to boot RAM as little-endian 32-bit words.
module i2c_boot_loader
  import boot_pkg::*;
#(
  parameter int         QUARTER   = 31,
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         NUM_WORDS = 256,
  parameter int         MAX_RETRY = 3,
  localparam int        AW        = $clog2(NUM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          scl_oe,
  output logic          sda_oe,
  input  logic          sda_i,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          boot_complete,
  output logic          boot_error
);

  localparam logic [7:0] CTRL_W = {DEV_ADDR, RW_WRITE};
  localparam logic [7:0] CTRL_R = {DEV_ADDR, RW_READ};
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  state_t     state;
  cmd_t       cmd;
  logic       cmd_valid;
  logic       wbit;
  logic       busy;
  logic       done;
  logic       rbit;
  logic [3:0] cnt;
  logic [1:0] sel;
  logic [1:0] bidx;
  logic [7:0] sh;
  logic [7:0] rx;
  logic [7:0] retry;
  logic [7:0] retry_n;
  logic       fail;
  logic       last;

  assign rx      = {sh[6:0], rbit};
  assign retry_n = retry + 8'd1;
  assign last    = (wr_addr == LAST_ADDR) && (bidx == 2'd3);

  i2c_bit_ctrl #(.QUARTER(QUARTER)) u_bit (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .wbit      (wbit),
    .busy      (busy),
    .done      (done),
    .rbit      (rbit),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd           <= CMD_PULSE;
      cmd_valid     <= 1'b0;
      wbit          <= 1'b1;
      cnt           <= 4'd0;
      sel           <= 2'd0;
      bidx          <= 2'd0;
      sh            <= 8'h00;
      retry         <= 8'd0;
      fail          <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= 32'h0;
      boot_complete <= 1'b0;
      boot_error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (wr_en && wr_addr != LAST_ADDR) wr_addr <= wr_addr + 1'b1;
      if (cmd_valid && !busy) cmd_valid <= 1'b0;
      unique case (state)
        IDLE, ERROR: if (start) begin
          state     <= RECOVER;
          cnt       <= 4'd0;
          sel       <= 2'd0;
          bidx      <= 2'd0;
          retry     <= 8'd0;
          fail      <= 1'b0;
          wr_addr   <= '0;
          cmd       <= CMD_PULSE;
          cmd_valid <= 1'b1;
        end
        RECOVER: if (done) begin
          cmd_valid <= 1'b1;
          if (cnt == 4'd8) begin
            state <= START;
            cmd   <= CMD_START;
          end else begin
            cnt <= cnt + 1'b1;
            cmd <= CMD_PULSE;
          end
        end
        START: if (done) begin
          state     <= TX_BYTE;
          cnt       <= 4'd0;
          sel       <= 2'd0;
          sh        <= {CTRL_W[6:0], 1'b0};
          wbit      <= CTRL_W[7];
          cmd       <= CMD_WBIT;
          cmd_valid <= 1'b1;
        end
        TX_BYTE: if (done) begin
          cmd_valid <= 1'b1;
          if (cnt == 4'd7) begin
            state <= TX_ACK;
            cmd   <= CMD_RBIT;
          end else begin
            cnt  <= cnt + 1'b1;
            cmd  <= CMD_WBIT;
            wbit <= sh[7];
            sh   <= {sh[6:0], 1'b0};
          end
        end
        TX_ACK: if (done) begin
          cmd_valid <= 1'b1;
          cnt       <= 4'd0;
          if (rbit) begin
            fail  <= 1'b1;
            state <= STOP;
            cmd   <= CMD_STOP;
          end else begin
            sel <= sel + 1'b1;
            unique case (sel)
              2'd0, 2'd1: begin
                state <= TX_BYTE;
                cmd   <= CMD_WBIT;
                wbit  <= 1'b0;
                sh    <= 8'h00;
              end
              2'd2: begin
                state <= RSTART;
                cmd   <= CMD_START;
              end
              default: begin
                state <= RX_BYTE;
                cmd   <= CMD_RBIT;
              end
            endcase
          end
        end
        RSTART: if (done) begin
          state     <= TX_BYTE;
          sh        <= {CTRL_R[6:0], 1'b0};
          wbit      <= CTRL_R[7];
          cmd       <= CMD_WBIT;
          cmd_valid <= 1'b1;
        end
        RX_BYTE: if (done) begin
          sh        <= rx;
          cmd_valid <= 1'b1;
          if (cnt == 4'd7) begin
            state <= RX_ACK;
            cmd   <= CMD_WBIT;
            wbit  <= last;
            bidx  <= bidx + 1'b1;
            wr_data[{bidx, 3'b000} +: 8] <= rx;
            if (bidx == 2'd3) wr_en <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            cmd <= CMD_RBIT;
          end
        end
        // wbit still holds the NACK flag of the final byte
        RX_ACK: if (done) begin
          cmd_valid <= 1'b1;
          cnt       <= 4'd0;
          if (wbit) begin
            state <= STOP;
            cmd   <= CMD_STOP;
          end else begin
            state <= RX_BYTE;
            cmd   <= CMD_RBIT;
          end
        end
        STOP: if (done) begin
          if (!fail) begin
            state         <= DONE;
            boot_complete <= 1'b1;
          end else begin
            retry <= retry_n;
            if (retry_n > 8'(MAX_RETRY)) begin
              state      <= ERROR;
              boot_error <= 1'b1;
            end else begin
              state     <= RECOVER;
              cnt       <= 4'd0;
              sel       <= 2'd0;
              fail      <= 1'b0;
              cmd       <= CMD_PULSE;
              cmd_valid <= 1'b1;
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
